// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end for the serial two's-complement negator: accepts a word,
// pulses the negator's clear, then shifts the word out LSB-first with first/last/done framing.
module serial_word_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  output logic             ser_clr,
  output logic             ser_x,
  output logic             ser_en,
  output logic             ser_first,
  output logic             ser_last,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  // Next-state logic; the count holds on the last bit so it never wraps.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sh_d    = in_data;
          cnt_d   = {CW{1'b0}};
          state_d = ST_CLR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLR: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!stall) begin
          sh_d = {1'b0, sh_q[WIDTH-1:1]};
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          sh_d  = sh_q;
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, shift register, bit count and done flag; synchronous reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sh_q    <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Output decode from registered state; stall only gates the bit-enable.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    ser_clr   = (state_q == ST_CLR);
    ser_en    = (state_q == ST_SHIFT) && !stall;
    ser_x     = ser_en ? sh_q[0] : 1'b0;
    ser_first = ser_en && (cnt_q == {CW{1'b0}});
    ser_last  = ser_en && (cnt_q == CNT_LAST);
    done      = done_q;
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: directed scenarios plus randomized words and stalls, checked
// against a bit-index model of the serialized word.
module tb_serial_word_feeder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         stall = 1'b0;
  logic         in_ready, ser_clr, ser_x, ser_en, ser_first, ser_last, done, busy;

  int checks = 0;
  int errors = 0;

  serial_word_feeder #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .ser_clr(ser_clr), .ser_x(ser_x), .ser_en(ser_en), .ser_first(ser_first),
    .ser_last(ser_last), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One idle cycle: nothing offered, done as expected, feeder ready.
  task automatic idle_cycle(input logic exp_done);
    in_valid = 1'b0;
    stall    = 1'(($urandom & 32'd1));
    in_data  = W'($urandom);
    #1;
    chk("idle_done", done, exp_done);
    chk("idle_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_en", ser_en, 0);
    chk("idle_clr", ser_clr, 0);
    @(negedge clk);
  endtask

  // Offer word w now, expect the clear cycle, then WIDTH bits (with stalls), then return at the
  // done cycle. abort_idx >= 0 applies reset during that bit and returns right after it.
  task automatic send_word(input logic [W-1:0] w, input logic exp_done, input int stall_pct,
                           input int stall_at, input int stall_len, input bit busy_pulse,
                           input int abort_idx);
    int idx = 0;
    int guard = 0;
    int stalled = 0;
    logic [W-1:0] got = '0;
    in_data  = w;
    in_valid = 1'b1;
    stall    = 1'(($urandom & 32'd1));
    #1;
    chk("accept_ready", in_ready, 1);
    chk("accept_busy", busy, 0);
    chk("accept_done", done, exp_done);
    chk("accept_en", ser_en, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = W'($urandom);
    stall    = 1'(($urandom & 32'd1));
    #1;
    chk("clr_pulse", ser_clr, 1);
    chk("clr_en", ser_en, 0);
    chk("clr_x", ser_x, 0);
    chk("clr_busy", busy, 1);
    chk("clr_done", done, 0);
    while (idx < W) begin
      @(negedge clk);
      guard++;
      if (guard > 64) begin
        chk("bit_timeout", idx, W);
        break;
      end
      if (idx == stall_at && stalled < stall_len) begin
        stall = 1'b1;
        stalled++;
      end else begin
        stall = ($urandom_range(0, 99) < stall_pct);
      end
      in_valid = busy_pulse && (guard == 3 || guard == 4);
      in_data  = busy_pulse ? 8'hAA : W'($urandom);
      if (!stall && idx == abort_idx) reset = 1'b1;
      #1;
      chk("bit_ready", in_ready, 0);
      chk("bit_busy", busy, 1);
      chk("bit_clr", ser_clr, 0);
      chk("bit_done", done, 0);
      if (stall) begin
        chk("stall_en", ser_en, 0);
        chk("stall_x", ser_x, 0);
        chk("stall_last", ser_last, 0);
      end else begin
        chk("bit_en", ser_en, 1);
        chk("bit_x", ser_x, w[idx]);
        chk("bit_first", ser_first, idx == 0);
        chk("bit_last", ser_last, idx == W - 1);
        got[idx] = ser_x;
        idx++;
        if (reset) begin
          @(negedge clk);
          reset    = 1'b0;
          in_valid = 1'b0;
          stall    = 1'b0;
          return;
        end
      end
    end
    chk("word_collected", got, w);
    in_valid = 1'b0;
    stall    = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset held two cycles with junk on the inputs.
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_en", ser_en, 0);
    chk("rst_clr", ser_clr, 0);
    chk("rst_done", done, 0);
    chk("rst_x", ser_x, 0);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    // 0x06, no stall, then the done cycle and one quiet cycle.
    send_word(8'h06, 1'b0, 0, -1, 0, 1'b0, -1);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // 0x80 with three stall cycles on bit 3.
    send_word(8'h80, 1'b0, 0, 3, 3, 1'b0, -1);
    idle_cycle(1'b1);

    // Back-to-back: 0xFF is accepted in 0x01's done cycle.
    send_word(8'h01, 1'b0, 0, -1, 0, 1'b0, -1);
    send_word(8'hFF, 1'b1, 0, -1, 0, 1'b0, -1);
    idle_cycle(1'b1);

    // Stall on the last bit delays ser_last and done.
    send_word(8'hC3, 1'b0, 0, 7, 2, 1'b0, -1);
    idle_cycle(1'b1);

    // Reset during bit 4: no done afterwards, then 0x55 goes through cleanly.
    send_word(8'h96, 1'b0, 0, -1, 0, 1'b0, 4);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    send_word(8'h55, 1'b0, 0, -1, 0, 1'b0, -1);
    idle_cycle(1'b1);

    // 0xAA offered while 0x0F is serializing must be ignored.
    send_word(8'h0F, 1'b0, 0, -1, 0, 1'b1, -1);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // Randomized words, stalls and back-to-back spacing.
    begin
      logic prev_done = 1'b0;
      for (int n = 0; n < 40; n++) begin
        if ($urandom_range(0, 2) == 0) begin
          idle_cycle(prev_done);
          prev_done = 1'b0;
        end
        send_word(W'($urandom), prev_done, 30, -1, 0, ($urandom_range(0, 3) == 0), -1);
        prev_done = 1'b1;
      end
      idle_cycle(prev_done);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
